// File: rtl/multicycle_control_if.sv
// Control/datapath bundle for the multi-cycle RV32 main controller.
// master: the control unit (drives enables and selects, reads opcode/flags).
// slave:  the datapath/memory side.
interface multicycle_control_if;
  logic [6:0] opcode;
  logic       zero;
  logic       mem_ready;
  logic       pc_write;
  logic       ir_write;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic [1:0] mem_to_reg;
  logic       reg_write;
  logic [1:0] alu_src_a;
  logic [1:0] alu_src_b;
  logic [1:0] alu_op;
  logic [1:0] pc_src;
  logic       illegal;
  logic       timeout;
  logic [3:0] state;

  modport master (
    input  opcode, zero, mem_ready,
    output pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal, timeout, state
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  pc_write, ir_write, i_or_d, mem_read, mem_write, mem_to_reg, reg_write,
           alu_src_a, alu_src_b, alu_op, pc_src, illegal, timeout, state
  );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32 main control FSM: fetch/decode/execute/memory/writeback
// sequencing, memory ready handshake with timeout, sticky illegal/timeout trap.
// Optional macro MULTICYCLE_CTRL_PERF_EN adds retired/stall_cycles counters.
module multicycle_control #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned PERF_W      = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  multicycle_control_if.master bus
`ifdef MULTICYCLE_CTRL_PERF_EN
  ,
  output logic [PERF_W-1:0]    retired,
  output logic [PERF_W-1:0]    stall_cycles
`endif
);

  typedef enum logic [3:0] {
    st_fetch    = 4'd0,
    st_decode   = 4'd1,
    st_exec_r   = 4'd2,
    st_exec_i   = 4'd3,
    st_mem_addr = 4'd4,
    st_mem_rd   = 4'd5,
    st_mem_wb   = 4'd6,
    st_mem_wr   = 4'd7,
    st_alu_wb   = 4'd8,
    st_branch   = 4'd9,
    st_jal      = 4'd10,
    st_trap     = 4'd15
  } state_e;

  // Keep at least one bit so a disabled timeout still elaborates cleanly.
  localparam int unsigned CntW = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              illegal_q, illegal_d;
  logic              timeout_q, timeout_d;
  logic              is_store_q, is_store_d;
  logic              waiting;
  logic              stall;

  // State, wait counter and sticky flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= st_fetch;
      cnt_q      <= '0;
      illegal_q  <= 1'b0;
      timeout_q  <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      illegal_q  <= illegal_d;
      timeout_q  <= timeout_d;
      is_store_q <= is_store_d;
    end
  end

  // Next state, trap detection and wait-counter update.
  always_comb begin
    state_d    = state_q;
    illegal_d  = illegal_q;
    timeout_d  = timeout_q;
    is_store_d = is_store_q;
    waiting    = 1'b0;
    unique case (state_q)
      st_fetch: begin
        waiting = 1'b1;
        if (bus.mem_ready) state_d = st_decode;
      end
      st_decode: begin
        // Load/store kind is latched here; opcode is ignored in later states.
        case (bus.opcode)
          7'b0110011: state_d = st_exec_r;
          7'b0010011: state_d = st_exec_i;
          7'b0000011: begin state_d = st_mem_addr; is_store_d = 1'b0; end
          7'b0100011: begin state_d = st_mem_addr; is_store_d = 1'b1; end
          7'b1100011: state_d = st_branch;
          7'b1101111: state_d = st_jal;
          default:    begin state_d = st_trap; illegal_d = 1'b1; end
        endcase
      end
      st_exec_r:   state_d = st_alu_wb;
      st_exec_i:   state_d = st_alu_wb;
      st_alu_wb:   state_d = st_fetch;
      st_mem_addr: state_d = is_store_q ? st_mem_wr : st_mem_rd;
      st_mem_rd: begin
        waiting = 1'b1;
        if (bus.mem_ready) state_d = st_mem_wb;
      end
      st_mem_wb:   state_d = st_fetch;
      st_mem_wr: begin
        waiting = 1'b1;
        if (bus.mem_ready) state_d = st_fetch;
      end
      st_branch:   state_d = st_fetch;
      st_jal:      state_d = st_fetch;
      st_trap:     state_d = st_trap;
      default:     state_d = st_trap;
    endcase

    stall = waiting && !bus.mem_ready;
    if (stall && (MEM_TIMEOUT != 0) && (cnt_q == CntW'(MEM_TIMEOUT))) begin
      state_d   = st_trap;
      timeout_d = 1'b1;
    end

    if (!stall || (state_d != state_q)) cnt_d = '0;
    else                                cnt_d = cnt_q + CntW'(1);
  end

  // Moore output decode; only pc_write/ir_write look at mem_ready or zero.
  always_comb begin
    bus.pc_write   = 1'b0;
    bus.ir_write   = 1'b0;
    bus.i_or_d     = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.mem_to_reg = 2'b00;
    bus.reg_write  = 1'b0;
    bus.alu_src_a  = 2'b00;
    bus.alu_src_b  = 2'b00;
    bus.alu_op     = 2'b00;
    bus.pc_src     = 2'b00;
    bus.illegal    = 1'b0;
    bus.timeout    = 1'b0;
    bus.state      = 4'd0;
    if (!rst) begin
      bus.illegal = illegal_q;
      bus.timeout = timeout_q;
      bus.state   = state_q;
      case (state_q)
        st_fetch: begin
          bus.mem_read  = 1'b1;
          bus.alu_src_b = 2'b01;
          bus.ir_write  = bus.mem_ready;
          bus.pc_write  = bus.mem_ready;
        end
        st_decode:   bus.alu_src_b = 2'b10;
        st_exec_r: begin
          bus.alu_src_a = 2'b01;
          bus.alu_op    = 2'b10;
        end
        st_exec_i: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
          bus.alu_op    = 2'b11;
        end
        st_mem_addr: begin
          bus.alu_src_a = 2'b01;
          bus.alu_src_b = 2'b10;
        end
        st_mem_rd: begin
          bus.mem_read = 1'b1;
          bus.i_or_d   = 1'b1;
        end
        st_mem_wb: begin
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 2'b01;
        end
        st_mem_wr: begin
          bus.mem_write = 1'b1;
          bus.i_or_d    = 1'b1;
        end
        st_alu_wb:   bus.reg_write = 1'b1;
        st_branch: begin
          bus.alu_src_a = 2'b01;
          bus.alu_op    = 2'b01;
          bus.pc_src    = 2'b01;
          bus.pc_write  = bus.zero;
        end
        st_jal: begin
          bus.pc_src     = 2'b01;
          bus.pc_write   = 1'b1;
          bus.reg_write  = 1'b1;
          bus.mem_to_reg = 2'b10;
        end
        default: ;
      endcase
    end
  end

`ifdef MULTICYCLE_CTRL_PERF_EN
  logic retire_ev;
  logic stall_ev;

  always_comb begin
    retire_ev = (state_d == st_fetch) &&
                ((state_q == st_alu_wb) || (state_q == st_mem_wb) || (state_q == st_mem_wr) ||
                 (state_q == st_branch) || (state_q == st_jal));
    stall_ev  = stall && (state_d == state_q);
  end

  // Free-running performance counters, wrapping at 2^PERF_W.
  always_ff @(posedge clk) begin
    if (rst) begin
      retired      <= '0;
      stall_cycles <= '0;
    end else begin
      if (retire_ev) retired <= retired + PERF_W'(1);
      if (stall_ev)  stall_cycles <= stall_cycles + PERF_W'(1);
    end
  end
`endif

endmodule
